// File: rtl/pipe_fetch_queue.sv
// Instruction-fetch stage: PC generator, 1-cycle imem request port and a
// DEPTH-entry prefetch queue that absorbs decode stalls; EX redirects flush it.
module pipe_fetch_queue #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [DATA_WIDTH-1:0]   imem_addr,
    input  logic [DATA_WIDTH-1:0]   imem_rdata,
    input  logic                    redirect_en,
    input  logic [DATA_WIDTH-1:0]   redirect_pc,
    input  logic                    stall_d,
    output logic                    instr_valid,
    output logic [DATA_WIDTH-1:0]   instr,
    output logic [DATA_WIDTH-1:0]   instr_pc,
    output logic [DATA_WIDTH-1:0]   instr_pc4,
    output logic [$clog2(DEPTH):0]  queue_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  inflight_q, inflight_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] pc_mem_q    [DEPTH];
    logic                  push_c;
    logic                  pop_c;

    // Issue reserves a queue slot for every in-flight request, so no overflow.
    always_comb begin
        imem_req  = !reset && !redirect_en &&
                    ((count_q + CW'(inflight_q)) < CW'(DEPTH));
        imem_addr = fetch_pc_q;
    end

    always_comb begin
        instr_valid = (count_q != '0);
        instr       = instr_valid ? instr_mem_q[rd_ptr_q] : '0;
        instr_pc    = instr_valid ? pc_mem_q[rd_ptr_q] : '0;
        instr_pc4   = instr_valid ? pc_mem_q[rd_ptr_q] + DATA_WIDTH'(4) : '0;
        queue_count = count_q;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = inflight_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        push_c     = inflight_q && !redirect_en;
        pop_c      = instr_valid && !stall_d;
        if (redirect_en) begin
            fetch_pc_d = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            inflight_d = imem_req;
            if (imem_req) begin
                fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
                req_pc_d   = fetch_pc_q;
            end
            if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_c) - CW'(pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage needs no reset; occupancy gates everything read from it.
    always_ff @(posedge clk) begin
        if (!reset && push_c) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Directed bench for pipe_fetch_queue: two instances (default and wrapping
// RESET_PC) driven by a registered imem that returns word = address.
module tb_pipe_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_d = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        req1, valid1, req2, valid2;
    logic [31:0] addr1, rdata1, instr1, pc1, pc41;
    logic [31:0] addr2, rdata2, instr2, pc2, pc42;
    logic [2:0]  cnt1, cnt2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_fetch_queue #(.DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0040_0000)) u_dut (
        .clk(clk), .reset(reset), .imem_req(req1), .imem_addr(addr1),
        .imem_rdata(rdata1), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .stall_d(stall_d), .instr_valid(valid1), .instr(instr1), .instr_pc(pc1),
        .instr_pc4(pc41), .queue_count(cnt1)
    );

    pipe_fetch_queue #(.DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2),
        .imem_rdata(rdata2), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .stall_d(stall_d), .instr_valid(valid2), .instr(instr2), .instr_pc(pc2),
        .instr_pc4(pc42), .queue_count(cnt2)
    );

    // Registered instruction memory: data appears the cycle after the request.
    always @(posedge clk) begin
        rdata1 <= req1 ? addr1 : 32'hDEAD_BEEF;
        rdata2 <= req2 ? addr2 : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle, apply its inputs, let combinational logic settle.
    task automatic cyc(input logic rst, input logic st, input logic ren, input logic [31:0] rpc);
        @(negedge clk);
        reset       = rst;
        stall_d     = st;
        redirect_en = ren;
        redirect_pc = rpc;
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        // Reset state and free-running fetch
        do_reset();
        chk("rst_req",   32'(req1),   32'h0);
        chk("rst_addr",  addr1,       32'h0040_0000);
        chk("rst_valid", 32'(valid1), 32'h0);
        chk("rst_instr", instr1,      32'h0);
        chk("rst_pc",    pc1,         32'h0);
        chk("rst_pc4",   pc41,        32'h0);
        chk("rst_cnt",   32'(cnt1),   32'h0);
        chk("rst_addr2", addr2,       32'hFFFF_FFF8);
        chk("rst_valid2", 32'(valid2), 32'h0);
        chk("rst_instr2", instr2,     32'h0);
        chk("rst_cnt2",  32'(cnt2),   32'h0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("c0_req",   32'(req1),   32'h1);
        chk("c0_addr",  addr1,       32'h0040_0000);
        chk("c0_valid", 32'(valid1), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("c1_valid", 32'(valid1), 32'h0);
        chk("c1_addr",  addr1,       32'h0040_0004);
        for (int k = 0; k < 16; k++) begin
            cyc(1'b0, 1'b0, 1'b0, '0);
            chk("run_valid", 32'(valid1), 32'h1);
            chk("run_pc",    pc1,   32'h0040_0000 + 32'(4 * k));
            chk("run_instr", instr1, 32'h0040_0000 + 32'(4 * k));
            chk("run_pc4",   pc41,  32'h0040_0004 + 32'(4 * k));
            chk("run_cnt",   32'(cnt1), 32'h1);
            if (k < 3) begin
                chk("wrap_pc",  pc2,  32'hFFFF_FFF8 + 32'(4 * k));
                chk("wrap_pc4", pc42, 32'hFFFF_FFFC + 32'(4 * k));
            end
        end

        // Ten-cycle stall from cycle 2, then drain
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        chk("st2_cnt", 32'(cnt1), 32'h1);
        chk("st2_req", 32'(req1), 32'h1);
        cyc(1'b0, 1'b1, 1'b0, '0);
        chk("st3_cnt", 32'(cnt1), 32'h2);
        chk("st3_req", 32'(req1), 32'h1);
        cyc(1'b0, 1'b1, 1'b0, '0);
        chk("st4_cnt", 32'(cnt1), 32'h3);
        chk("st4_req", 32'(req1), 32'h0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b1, 1'b0, '0);
            chk("stf_cnt", 32'(cnt1), 32'h4);
            chk("stf_req", 32'(req1), 32'h0);
            chk("stf_pc",  pc1, 32'h0040_0000);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 1'b0, '0);
            chk("drain_pc",  pc1, 32'h0040_0000 + 32'(4 * i));
            chk("drain_cnt", 32'(cnt1), (i == 0) ? 32'h4 : (i == 1) ? 32'h3 : 32'h2);
            if (i == 0) chk("drain_req0", 32'(req1), 32'h0);
            if (i == 1) begin
                chk("drain_req1",  32'(req1), 32'h1);
                chk("drain_addr1", addr1, 32'h0040_0010);
            end
        end

        // Push+pop at count=DEPTH-1 and pointer wrap over 16 instructions
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b0, 1'b0, '0);
            chk("wr_pc",  pc1, 32'h0040_0000 + 32'(4 * i));
            chk("wr_cnt", 32'(cnt1), (i < 2) ? 32'h3 : 32'h2);
        end

        // Redirect with 3 queued entries and one request in flight
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b1, 32'h0040_0103);
        chk("rd_pre_cnt", 32'(cnt1), 32'h3);
        chk("rd_req",     32'(req1), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("rd1_valid", 32'(valid1), 32'h0);
        chk("rd1_cnt",   32'(cnt1), 32'h0);
        chk("rd1_req",   32'(req1), 32'h1);
        chk("rd1_addr",  addr1, 32'h0040_0100);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("rd2_valid", 32'(valid1), 32'h0);
        chk("rd2_addr",  addr1, 32'h0040_0104);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("rd3_valid", 32'(valid1), 32'h1);
        chk("rd3_pc",    pc1, 32'h0040_0100);
        chk("rd3_instr", instr1, 32'h0040_0100);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("rd4_pc",    pc1, 32'h0040_0104);

        // Back-to-back redirects: later target wins
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b1, 32'h0040_0200);
        chk("bb0_req", 32'(req1), 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'h0040_0300);
        chk("bb1_req",   32'(req1), 32'h0);
        chk("bb1_valid", 32'(valid1), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("bb2_req",   32'(req1), 32'h1);
        chk("bb2_addr",  addr1, 32'h0040_0300);
        chk("bb2_valid", 32'(valid1), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("bb3_valid", 32'(valid1), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, '0);
            chk("bb_pc", pc1, 32'h0040_0300 + 32'(4 * i));
        end

        // Reset mid-stream with a full queue
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, '0);
        chk("mr_full", 32'(cnt1), 32'h4);
        cyc(1'b1, 1'b1, 1'b0, '0);
        chk("mr_req_in_rst", 32'(req1), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("mr_valid", 32'(valid1), 32'h0);
        chk("mr_cnt",   32'(cnt1), 32'h0);
        chk("mr_instr", instr1, 32'h0);
        chk("mr_pc",    pc1, 32'h0);
        chk("mr_pc4",   pc41, 32'h0);
        chk("mr_req",   32'(req1), 32'h1);
        chk("mr_addr",  addr1, 32'h0040_0000);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("mr1_valid", 32'(valid1), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("mr2_valid", 32'(valid1), 32'h1);
        chk("mr2_pc",    pc1, 32'h0040_0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
